// File: rtl/shake_pkg.sv
// Shared SHAKE/Keccak definitions: widths, rates and the squeeze FSM encoding.
package shake_pkg;

  localparam int STATE_WIDTH   = 1600;
  localparam int RATE_SHAKE256 = 1088;
  localparam int RATE_SHAKE128 = 1344;
  localparam int LANE_W        = 64;

  typedef enum logic [2:0] {
    SQ_IDLE      = 3'd0,
    SQ_EMIT      = 3'd1,
    SQ_PERM_REQ  = 3'd2,
    SQ_PERM_WAIT = 3'd3,
    SQ_DONE      = 3'd4
  } sq_state_e;

  // Number of output words that fit in one rate block.
  function automatic int words_per_block(input int rate, input int out_w);
    return rate / out_w;
  endfunction

endpackage

// File: rtl/shake_squeeze_stream.sv
// Multi-block SHAKE squeeze engine. Streams the rate part of the Keccak state
// as OUT_W-bit words under valid/ready and asks an external Keccak-f[1600]
// core for a fresh block whenever the current one has been fully emitted.
module shake_squeeze_stream #(
  parameter int STATE_WIDTH = 1600,
  parameter int RATE        = 1088,
  parameter int OUT_W       = 64,
  parameter int LEN_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   squeeze_start,
  input  logic [LEN_W-1:0]       out_len,
  input  logic [STATE_WIDTH-1:0] initial_state,
  output logic [OUT_W-1:0]       dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_last,
  output logic                   perm_start,
  output logic [STATE_WIDTH-1:0] perm_state_out,
  input  logic                   perm_done,
  input  logic [STATE_WIDTH-1:0] perm_state_in,
  output logic                   squeeze_done,
  output logic                   busy
);
  import shake_pkg::*;

  localparam int WPB   = words_per_block(RATE, OUT_W);
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WPB - 1);

  sq_state_e              fsm_q, fsm_d;
  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [OUT_W-1:0]       dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   dout_last_q, dout_last_d;
  logic                   perm_start_q, perm_start_d;
  logic                   squeeze_done_q, squeeze_done_d;
  logic                   busy_q, busy_d;
  logic                   hs_s;

  // Word k of a block sits at bits [k*OUT_W +: OUT_W], lowest word first.
  function automatic logic [OUT_W-1:0] word_sel(input logic [STATE_WIDTH-1:0] st,
                                                input logic [IDX_W-1:0] k);
    int base;
    base = int'(k) * OUT_W;
    return st[base +: OUT_W];
  endfunction

  assign hs_s = dout_valid_q & dout_ready;

  // Next-state and next-output computation for the squeeze sequencer.
  always_comb begin
    fsm_d          = fsm_q;
    state_d        = state_q;
    remaining_d    = remaining_q;
    idx_d          = idx_q;
    dout_d         = dout_q;
    dout_valid_d   = dout_valid_q;
    dout_last_d    = dout_last_q;
    perm_start_d   = 1'b0;
    squeeze_done_d = 1'b0;

    case (fsm_q)
      SQ_IDLE: begin
        if (squeeze_start) begin
          if (out_len != LEN_W'(0)) begin
            state_d      = initial_state;
            remaining_d  = out_len;
            idx_d        = '0;
            dout_d       = initial_state[OUT_W-1:0];
            dout_valid_d = 1'b1;
            dout_last_d  = (out_len == LEN_W'(1));
            fsm_d        = SQ_EMIT;
          end else begin
            squeeze_done_d = 1'b1;
            fsm_d          = SQ_DONE;
          end
        end else begin
          fsm_d = SQ_IDLE;
        end
      end

      SQ_EMIT: begin
        if (hs_s) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            // Final word accepted: stop emitting and report completion.
            dout_valid_d   = 1'b0;
            dout_last_d    = 1'b0;
            squeeze_done_d = 1'b1;
            fsm_d          = SQ_DONE;
          end else if (idx_q == IDX_LAST) begin
            // Block exhausted: idx is cleared when the new block lands.
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            perm_start_d = 1'b1;
            fsm_d        = SQ_PERM_REQ;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            dout_d      = word_sel(state_q, idx_q + IDX_W'(1));
            dout_last_d = (remaining_q == LEN_W'(2));
          end
        end else begin
          fsm_d = SQ_EMIT;
        end
      end

      SQ_PERM_REQ: begin
        fsm_d = SQ_PERM_WAIT;
      end

      SQ_PERM_WAIT: begin
        if (perm_done) begin
          state_d      = perm_state_in;
          idx_d        = '0;
          dout_d       = perm_state_in[OUT_W-1:0];
          dout_valid_d = 1'b1;
          dout_last_d  = (remaining_q == LEN_W'(1));
          fsm_d        = SQ_EMIT;
        end else begin
          fsm_d = SQ_PERM_WAIT;
        end
      end

      SQ_DONE: begin
        fsm_d = SQ_IDLE;
      end

      default: begin
        fsm_d        = SQ_IDLE;
        dout_valid_d = 1'b0;
        dout_last_d  = 1'b0;
      end
    endcase

    busy_d = (fsm_d != SQ_IDLE);
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q          <= SQ_IDLE;
      state_q        <= '0;
      remaining_q    <= '0;
      idx_q          <= '0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      dout_last_q    <= 1'b0;
      perm_start_q   <= 1'b0;
      squeeze_done_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      fsm_q          <= fsm_d;
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      idx_q          <= idx_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      dout_last_q    <= dout_last_d;
      perm_start_q   <= perm_start_d;
      squeeze_done_q <= squeeze_done_d;
      busy_q         <= busy_d;
    end
  end

  // The held block register is what the permutation consumes; it only
  // changes when the permuted state is accepted, so it stays stable.
  assign perm_state_out = state_q;
  assign dout           = dout_q;
  assign dout_valid     = dout_valid_q;
  assign dout_last      = dout_last_q;
  assign perm_start     = perm_start_q;
  assign squeeze_done   = squeeze_done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_shake_squeeze_stream.sv
// Scoreboard bench for shake_squeeze_stream: stimulus pushes expected words,
// a negedge monitor pops and compares, a stub models the permutation core.
module tb_shake_squeeze_stream;

  localparam int SW  = 1600;
  localparam int OW  = 64;
  localparam int LW  = 16;
  localparam int WPB = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          squeeze_start = 1'b0;
  logic [LW-1:0] out_len = '0;
  logic [SW-1:0] initial_state = '0;
  logic [OW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready = 1'b0;
  logic          dout_last;
  logic          perm_start;
  logic [SW-1:0] perm_state_out;
  logic          perm_done = 1'b0;
  logic [SW-1:0] perm_state_in = '0;
  logic          squeeze_done;
  logic          busy;

  shake_squeeze_stream #(.STATE_WIDTH(SW), .RATE(1088), .OUT_W(OW), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .squeeze_start(squeeze_start), .out_len(out_len),
    .initial_state(initial_state), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .perm_start(perm_start),
    .perm_state_out(perm_state_out), .perm_done(perm_done),
    .perm_state_in(perm_state_in), .squeeze_done(squeeze_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] w;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [SW-1:0] perm_exp_q[$];
  exp_t          mon_e;
  logic [SW-1:0] stub_pe;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cycle = 0;
  int last_hs_cycle = 0;
  int first_hs_cycle = -1;
  int valid_seen = 0;
  int perm_cnt = 0;
  bit rnd_ready = 1'b0;
  bit stall_pend = 1'b0;
  logic [OW-1:0] stall_w;
  logic          stall_l;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dout"}, dout, 64'd0);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_last"}, 64'(dout_last), 64'd0);
    chk({tag, "_perm_start"}, 64'(perm_start), 64'd0);
    chk({tag, "_squeeze_done"}, 64'(squeeze_done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    n_cmp++;
    if (perm_state_out !== '0) begin
      n_bad++;
      $display("FAIL %s_perm_state_out: got low %h expected 0", tag, perm_state_out[63:0]);
    end
  endtask

  function automatic logic [SW-1:0] make_words(input logic [63:0] base, input logic [63:0] step);
    logic [SW-1:0] st;
    st = '0;
    for (int k = 0; k < SW / OW; k++) st[k*OW +: OW] = base + 64'(k) * step;
    return st;
  endfunction

  // Cycle counter, advanced on each active edge.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_ready) dout_ready = ($urandom_range(0, 1) == 1);
  end

  // Monitor: pops expected words on handshake, checks hold during stalls.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (dout_valid) valid_seen++;
      if (squeeze_done) begin
        done_cnt++;
        done_cycle = cyc;
      end
      if (stall_pend) begin
        chk("stall_dout", dout, stall_w);
        chk("stall_last", 64'(dout_last), 64'(stall_l));
        chk("stall_valid", 64'(dout_valid), 64'd1);
      end
      stall_pend = 1'b0;
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected none", dout);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dout", dout, mon_e.w);
          chk("dout_last", 64'(dout_last), 64'(mon_e.last));
        end
        if (first_hs_cycle < 0) first_hs_cycle = cyc;
        last_hs_cycle = cyc;
      end else if (dout_valid) begin
        stall_pend = 1'b1;
        stall_w    = dout;
        stall_l    = dout_last;
      end
    end
  end

  // Permutation stub: answers ~state three cycles after the request.
  initial forever begin
    @(negedge clk);
    if (!reset && perm_start) begin
      perm_cnt++;
      n_cmp++;
      if (perm_exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL perm_state_out: got low %h expected no request", perm_state_out[63:0]);
      end else begin
        stub_pe = perm_exp_q.pop_front();
        if (perm_state_out !== stub_pe) begin
          n_bad++;
          $display("FAIL perm_state_out: got low %h expected low %h",
                   perm_state_out[63:0], stub_pe[63:0]);
        end
      end
      repeat (2) @(posedge clk);
      #1;
      perm_state_in = ~perm_state_out;
      perm_done     = 1'b1;
      @(posedge clk);
      #1;
      perm_done = 1'b0;
    end
  end

  // rst_mode: 0 none, 1 reset at loop cycle rst_at, 2 reset while waiting on the permutation.
  task automatic run(input int len, input logic [SW-1:0] st, input bit rnd,
                     input int poke_at, input int rst_mode, input int rst_at);
    logic [SW-1:0] blk;
    exp_t e;
    int eperm, p0, d0, v0, s_cyc;
    bit did_rst;
    blk = st;
    for (int i = 0; i < len; i++) begin
      e.w    = blk[(i % WPB)*OW +: OW];
      e.last = (i == len - 1);
      exp_q.push_back(e);
      if ((i % WPB) == WPB - 1 && i != len - 1) begin
        perm_exp_q.push_back(blk);
        blk = ~blk;
      end
    end
    eperm = (len == 0) ? 0 : (len + WPB - 1) / WPB - 1;
    p0 = perm_cnt;
    d0 = done_cnt;
    v0 = valid_seen;
    first_hs_cycle = -1;
    did_rst = 1'b0;

    @(posedge clk);
    #1;
    rnd_ready = rnd;
    if (!rnd) dout_ready = 1'b1;
    squeeze_start = 1'b1;
    out_len       = LW'(len);
    initial_state = st;
    s_cyc = cyc;
    @(posedge clk);
    #1;
    squeeze_start = 1'b0;
    out_len       = 16'hFFFF;
    initial_state = ~st;

    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      squeeze_start = (i == poke_at);
      if ((rst_mode == 1 && i == rst_at) || (rst_mode == 2 && perm_cnt > p0)) begin
        reset = 1'b1;
        #1;
        check_zero("reset_mid");
        exp_q.delete();
        perm_exp_q.delete();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        did_rst = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    squeeze_start = 1'b0;
    rnd_ready     = 1'b0;

    if (did_rst) begin
      repeat (4) @(posedge clk);
      #1;
      chk("post_reset_valid", 64'(dout_valid), 64'd0);
      chk("post_reset_busy", 64'(busy), 64'd0);
      chk("post_reset_done", 64'(done_cnt - d0), 64'd0);
    end else begin
      if (done_cnt == d0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got no squeeze_done expected one (len %0d)", len);
      end
      chk("words_left", 64'(exp_q.size()), 64'd0);
      chk("perm_count", 64'(perm_cnt - p0), 64'(eperm));
      chk("busy_idle", 64'(busy), 64'd0);
      if (len == 0) begin
        chk("done_lat_empty", 64'(done_cycle), 64'(s_cyc + 1));
        chk("valid_never", 64'(valid_seen - v0), 64'd0);
      end else begin
        chk("done_lat", 64'(done_cycle), 64'(last_hs_cycle + 1));
        if (!rnd) chk("start_lat", 64'(first_hs_cycle), 64'(s_cyc + 1));
      end
    end
    dout_ready = 1'b0;
  endtask

  logic [SW-1:0] ones_st;

  // Directed test sequence.
  initial begin
    ones_st = '0;
    ones_st[1087:0] = '1;
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(17, ones_st, 1'b0, -1, 0, 0);
    run(17, make_words(64'd0, 64'd1), 1'b0, -1, 0, 0);
    run(20, make_words(64'h0123_4567_89AB_0000, 64'h111), 1'b0, -1, 0, 0);
    run(40, make_words(64'hDEAD_0000_0000_0000, 64'd7), 1'b1, -1, 0, 0);
    run(0, make_words(64'h5555_0000_0000_0000, 64'd1), 1'b0, -1, 0, 0);
    run(17, make_words(64'h1000_0000_0000_0000, 64'd5), 1'b0, 5, 0, 0);
    run(40, make_words(64'h2000_0000_0000_0000, 64'd9), 1'b0, -1, 1, 5);
    run(20, make_words(64'h3000_0000_0000_0000, 64'd11), 1'b0, -1, 2, 0);
    run(17, make_words(64'hCAFE_0000_0000_0000, 64'd3), 1'b0, -1, 0, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shake_squeeze_stream.md
# shake_squeeze_stream

Multi-block SHAKE squeeze engine that produces an arbitrary-length XOF output stream as OUT_W-bit words under a valid/ready handshake. It replaces the single-block squeeze, which returned only the first RATE bits in one shot. The block loads the post-absorb Keccak state and emits the rate portion word by word. When more output is requested than one block holds, it invokes the external Keccak-f[1600] permutation through a start/done handshake and continues. It sits between the absorb stage and the consumer (sampler or output FIFO).

## Interface
Parameters:
- STATE_WIDTH, 1600: Keccak state width.
- RATE, 1088: rate in bits (1088 for SHAKE256, 1344 for SHAKE128). Must be a multiple of OUT_W.
- OUT_W, 64: output word width.
- LEN_W, 16: width of the requested word count.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous, active-high reset.
- squeeze_start, in, 1: start request, sampled in IDLE only.
- out_len, in, LEN_W: number of OUT_W words to emit, sampled with squeeze_start.
- initial_state, in, STATE_WIDTH: post-absorb state, sampled with squeeze_start.
- dout, out, OUT_W: current output word.
- dout_valid, out, 1: dout holds a valid word.
- dout_ready, in, 1: consumer accepts the word.
- dout_last, out, 1: the current word is the final one.
- perm_start, out, 1: one-cycle request to the permutation.
- perm_state_out, out, STATE_WIDTH: state handed to the permutation.
- perm_done, in, 1: permutation result is valid (one-cycle pulse).
- perm_state_in, in, STATE_WIDTH: permuted state.
- squeeze_done, out, 1: one-cycle completion pulse.
- busy, out, 1: high in every state except IDLE.

## Operation
- WPB = RATE/OUT_W words per block (17 at the defaults).
- Word k of a block is state_reg[k*OUT_W +: OUT_W], with the lowest bits first. The first word is therefore initial_state[OUT_W-1:0].
- FSM states: IDLE, EMIT, PERM_REQ, PERM_WAIT, DONE.
- IDLE:
  - squeeze_start=1 with out_len≠0 → latch the state, set remaining=out_len and idx=0, go to EMIT.
  - squeeze_start=1 with out_len=0 → go to DONE.
- EMIT:
  - dout_valid=1 and dout=word idx.
  - dout_last=1 when remaining==1.
  - On a handshake (valid&ready): decrement remaining and increment idx.
  - Handshake with remaining==1 → DONE.
  - Otherwise, handshake with idx==WPB-1 → PERM_REQ.
- PERM_REQ:
  - perm_start=1 for exactly one cycle; perm_state_out=state_reg, held stable until perm_done.
  - Next state is PERM_WAIT.
- PERM_WAIT:
  - dout_valid=0.
  - On perm_done: state_reg←perm_state_in, idx←0, go to EMIT.
- DONE: squeeze_done=1 for one cycle, then IDLE.
- squeeze_start outside IDLE is ignored.
- perm_done outside PERM_WAIT is ignored.
- Number of permutations invoked = ceil(out_len/WPB)−1.
- remaining is LEN_W bits and never wraps. idx is clog2(WPB) bits and is reset to 0, never wrapped.

## Timing
- All outputs are registered or driven from registers.
- Reset values: dout=0, dout_valid=0, dout_last=0, perm_start=0, perm_state_out=0, squeeze_done=0, busy=0, FSM=IDLE, state_reg=0.
- reset is asynchronous in every state:
  - An in-flight perm_done arriving after reset is ignored.
  - A new squeeze_start after reset release behaves normally.
- Start latency: squeeze_start sampled at edge N → dout_valid=1 and the first word on dout after edge N.
- Throughput: one word per cycle while dout_ready=1.
- While dout_valid=1 and dout_ready=0, dout and dout_last are held stable.
- Block boundary:
  - Handshake of word WPB-1 at edge M → perm_start high after M, for one cycle.
  - perm_done sampled at edge P → next word valid after P.
  - Bubble = 1 cycle plus the permutation latency.
- squeeze_done:
  - Goes high the cycle after the last handshake.
  - With out_len=0, goes high the cycle after start.
- busy falls together with squeeze_done's deassertion.

## Structure
- Shared package shake_pkg holds:
  - STATE_WIDTH=1600, RATE_SHAKE256=1088, RATE_SHAKE128=1344, LANE_W=64.
  - The squeeze FSM state enum.
- No sub-module: the permutation is the existing external Keccak-f[1600] core, reached through the perm_* handshake.
- The word select is an indexed part-select mux in this module.

## Test plan
- **Single-block output:** initial_state={512'b0, 1088 ones}, out_len=17, dout_ready=1 → 17 words of 64'hFFFF_FFFF_FFFF_FFFF on consecutive cycles. Required: dout_last on word 17, no perm_start, squeeze_done one cycle later.
- **Word order:** word k of initial_state = k, for k=0..16; out_len=17 → dout sequence 0,1,…,16.
- **Multi-block:** out_len=20 with a stub that returns ~state after 3 cycles. Required:
  - Exactly one perm_start, with perm_state_out equal to the loaded state.
  - Words 18–20 equal ~word0..~word2.
  - dout_last on word 20.
- **Backpressure:** random 50% dout_ready with out_len=40 → every word delivered exactly once, in order. dout is stable during stalls and 2 permutations occur.
- **Empty request:** out_len=0 → squeeze_done pulses the cycle after start; dout_valid never rises.
- **Robustness:**
  - squeeze_start asserted during EMIT is ignored.
  - reset asserted mid-EMIT and during PERM_WAIT → all outputs 0 immediately.
  - A late perm_done is ignored.
  - A subsequent out_len=17 run passes.
